// File: rtl/pc_select_unit.sv
// pc_select_unit: fetch-stage PC generation for the 5-stage Y86-64 pipeline.
// Holds the predicted-PC register and selects the fetch address each cycle
// from the prediction, M-stage branch recovery or the W-stage return target.
// Optional return-address stack enabled by defining PCSEL_RAS_EN.
module pc_select_unit #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_stall,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic [3:0]        m_icode,
  input  logic              m_cnd,
  input  logic [ADDR_W-1:0] m_valA,
  input  logic [3:0]        w_icode,
  input  logic [ADDR_W-1:0] w_valM,
  input  logic [ADDR_W-1:0] w_ras_pred,
  output logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] pred_pc,
  output logic [1:0]        pc_src,
  output logic              redirect,
  output logic [ADDR_W-1:0] f_ras_pred,
  output logic              ras_mispredict
);

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  logic              br_mispred;
  logic              ret_redirect;
  logic [ADDR_W-1:0] next_pred;

  // A JXX reaching M with a false condition was mispredicted taken.
  assign br_mispred = (m_icode == I_JXX) && !m_cnd;

`ifdef PCSEL_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  // ras_ptr is the next free slot; the top of stack sits just below it.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W-1:0]  ras_top;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_push;
  logic              ras_pop;

  assign ras_top        = ras_ptr - PTR_W'(1);
  assign f_ras_pred     = (ras_cnt != '0) ? ras_mem[ras_top] : f_valP;
  assign ret_redirect   = (w_icode == I_RET) && (w_valM != w_ras_pred);
  assign ras_mispredict = ret_redirect;

  // Only instructions that will really proceed down the pipe touch the stack.
  assign ras_push = !f_stall && !redirect && (f_icode == I_CALL);
  assign ras_pop  = !f_stall && !redirect && (f_icode == I_RET) && (ras_cnt != '0);

  // Stack pointer and occupancy; a full push overwrites the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (ras_pop) begin
      ras_ptr <= ras_top;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  // Stack storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_ptr] <= f_valP;
  end
`else
  logic ras_pred_unused;

  assign ras_pred_unused = ^w_ras_pred;
  assign ret_redirect    = (w_icode == I_RET);
  assign f_ras_pred      = '0;
  assign ras_mispredict  = 1'b0;
`endif

  // Fetch address selection: branch recovery beats return redirect.
  always_comb begin
    f_pc   = pred_pc;
    pc_src = 2'd0;
    if (br_mispred) begin
      f_pc   = m_valA;
      pc_src = 2'd1;
    end else if (ret_redirect) begin
      f_pc   = w_valM;
      pc_src = 2'd2;
    end
  end

  assign redirect = (pc_src != 2'd0);

  // Next prediction: branches and calls predicted taken, RET from the stack.
  always_comb begin
    next_pred = f_valP;
    case (f_icode)
      I_JXX, I_CALL: next_pred = f_valC;
`ifdef PCSEL_RAS_EN
      I_RET:         next_pred = f_ras_pred;
`endif
      default:       next_pred = f_valP;
    endcase
  end

  // Predicted-PC register; loads every unstalled cycle, redirect or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pred_pc <= RESET_PC;
    else if (!f_stall) pred_pc <= next_pred;
  end

endmodule

// File: tb/tb_pc_select_unit.sv
// tb_pc_select_unit: randomized and directed bench for pc_select_unit with a
// queue-based reference model of the prediction register and return stack.
module tb_pc_select_unit;

  localparam int          AW    = 64;
  localparam logic [63:0] RPC   = 64'h100;
  localparam int          DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_stall;
  logic [3:0]    f_icode;
  logic [AW-1:0] f_valC, f_valP;
  logic [3:0]    m_icode;
  logic          m_cnd;
  logic [AW-1:0] m_valA;
  logic [3:0]    w_icode;
  logic [AW-1:0] w_valM, w_ras_pred;
  logic [AW-1:0] f_pc, pred_pc, f_ras_pred;
  logic [1:0]    pc_src;
  logic          redirect, ras_mispredict;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [AW-1:0] exp_pred;
  logic [AW-1:0] ras_q[$];
  logic [AW-1:0] e_fpc, e_rasp;
  logic [1:0]    e_src;
  logic          e_red, e_misp;

  pc_select_unit #(.ADDR_W(AW), .RESET_PC(RPC), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .f_stall(f_stall), .f_icode(f_icode),
    .f_valC(f_valC), .f_valP(f_valP), .m_icode(m_icode), .m_cnd(m_cnd),
    .m_valA(m_valA), .w_icode(w_icode), .w_valM(w_valM), .w_ras_pred(w_ras_pred),
    .f_pc(f_pc), .pred_pc(pred_pc), .pc_src(pc_src), .redirect(redirect),
    .f_ras_pred(f_ras_pred), .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Expected combinational outputs from the current model state and inputs.
  function automatic void model_eval();
    logic ret_hit;
`ifdef PCSEL_RAS_EN
    e_rasp  = (ras_q.size() > 0) ? ras_q[$] : f_valP;
    ret_hit = (w_icode == 4'h9) && (w_valM != w_ras_pred);
    e_misp  = ret_hit;
`else
    e_rasp  = '0;
    ret_hit = (w_icode == 4'h9);
    e_misp  = 1'b0;
`endif
    if (m_icode == 4'h7 && !m_cnd) begin e_fpc = m_valA;   e_src = 2'd1; end
    else if (ret_hit)              begin e_fpc = w_valM;   e_src = 2'd2; end
    else                           begin e_fpc = exp_pred; e_src = 2'd0; end
    e_red = (e_src != 2'd0);
  endfunction

  // Advance one clock and update the model with what the edge should do.
  task automatic tick();
    model_eval();
    if (!f_stall) begin
      if (f_icode == 4'h7 || f_icode == 4'h8) exp_pred = f_valC;
`ifdef PCSEL_RAS_EN
      else if (f_icode == 4'h9)               exp_pred = e_rasp;
`endif
      else                                    exp_pred = f_valP;
`ifdef PCSEL_RAS_EN
      if (!e_red) begin
        if (f_icode == 4'h8) begin
          ras_q.push_back(f_valP);
          if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
        end else if (f_icode == 4'h9 && ras_q.size() > 0) begin
          void'(ras_q.pop_back());
        end
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_stall = 0; f_icode = 4'h1; f_valC = '0; f_valP = '0;
    m_icode = 4'h0; m_cnd = 0; m_valA = '0;
    w_icode = 4'h0; w_valM = '0; w_ras_pred = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    exp_pred = RPC; ras_q.delete();
    total++; if (pred_pc !== 64'h100) begin bad++; $display("FAIL reset_pred got=%h want=%h", pred_pc, 64'h100); end
    total++; if (f_pc !== 64'h100)    begin bad++; $display("FAIL reset_fpc got=%h want=%h", f_pc, 64'h100); end
    total++; if (pc_src !== 2'd0)     begin bad++; $display("FAIL reset_src got=%0d want=0", pc_src); end
    total++; if (ras_mispredict !== 1'b0) begin bad++; $display("FAIL reset_misp got=%b want=0", ras_mispredict); end
    reset = 0;
    f_icode = 4'h6; f_valP = 64'h102;
    tick();
    total++; if (pred_pc !== 64'h102) begin bad++; $display("FAIL op_update got=%h want=%h", pred_pc, 64'h102); end
  endtask

  task automatic test_branch();
    idle();
    f_icode = 4'h7; f_valC = 64'h40; f_valP = 64'h209;
    tick();
    total++; if (pred_pc !== 64'h40) begin bad++; $display("FAIL jxx_pred got=%h want=%h", pred_pc, 64'h40); end
    idle(); f_valP = 64'h42;
    tick();
    m_icode = 4'h7; m_cnd = 0; m_valA = 64'h209;
    #1;
    total++; if (f_pc !== 64'h209) begin bad++; $display("FAIL br_recover_fpc got=%h want=%h", f_pc, 64'h209); end
    total++; if (pc_src !== 2'd1 || redirect !== 1'b1) begin bad++; $display("FAIL br_recover_src got=%0d/%b want=1/1", pc_src, redirect); end
    m_cnd = 1;
    #1;
    total++; if (f_pc !== 64'h42 || pc_src !== 2'd0) begin bad++; $display("FAIL br_taken got=%h/%0d want=%h/0", f_pc, pc_src, 64'h42); end
  endtask

  task automatic test_priority();
    idle();
    m_icode = 4'h7; m_cnd = 0; m_valA = 64'h30;
    w_icode = 4'h9; w_valM = 64'h50; w_ras_pred = 64'h10;
    #1;
    total++; if (f_pc !== 64'h30 || pc_src !== 2'd1) begin bad++; $display("FAIL prio got=%h/%0d want=%h/1", f_pc, pc_src, 64'h30); end
`ifdef PCSEL_RAS_EN
    total++; if (ras_mispredict !== 1'b1) begin bad++; $display("FAIL prio_misp got=%b want=1", ras_mispredict); end
`endif
    tick();
  endtask

  task automatic test_stall();
    logic [AW-1:0] held;
    idle();
    held = exp_pred;
    f_stall = 1; f_icode = 4'h8; f_valC = 64'h500; f_valP = 64'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pred_pc !== held) begin bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, pred_pc, held); end
    end
    f_stall = 0;
    tick();
    total++; if (pred_pc !== 64'h500) begin bad++; $display("FAIL stall_release got=%h want=%h", pred_pc, 64'h500); end
    // One push only: the stall cycles must not have pushed anything.
    f_icode = 4'h9; f_valP = 64'h600;
    #1;
    model_eval();
    total++; if (f_ras_pred !== e_rasp) begin bad++; $display("FAIL stall_ras got=%h want=%h", f_ras_pred, e_rasp); end
    tick();
    model_eval();
    total++; if (f_ras_pred !== e_rasp) begin bad++; $display("FAIL stall_ras_pop got=%h want=%h", f_ras_pred, e_rasp); end
  endtask

  task automatic test_return();
    idle();
`ifdef PCSEL_RAS_EN
    f_icode = 4'h8; f_valC = 64'h700; f_valP = 64'h10;
    tick();
    f_icode = 4'h9; f_valP = 64'h704;
    #1;
    total++; if (f_ras_pred !== 64'h10) begin bad++; $display("FAIL ret_pred got=%h want=%h", f_ras_pred, 64'h10); end
    tick();
    total++; if (pred_pc !== 64'h10) begin bad++; $display("FAIL ret_pc got=%h want=%h", pred_pc, 64'h10); end
    idle();
    w_icode = 4'h9; w_valM = 64'h10; w_ras_pred = 64'h10;
    #1;
    total++; if (pc_src !== 2'd0 || ras_mispredict !== 1'b0) begin bad++; $display("FAIL ret_ok got=%0d/%b want=0/0", pc_src, ras_mispredict); end
    w_valM = 64'h88;
    #1;
    total++; if (f_pc !== 64'h88 || ras_mispredict !== 1'b1 || pc_src !== 2'd2) begin bad++; $display("FAIL ret_bad got=%h/%b/%0d want=88/1/2", f_pc, ras_mispredict, pc_src); end
`else
    w_icode = 4'h9; w_valM = 64'h77; w_ras_pred = 64'h77;
    #1;
    total++; if (f_pc !== 64'h77 || pc_src !== 2'd2) begin bad++; $display("FAIL ret_redirect got=%h/%0d want=77/2", f_pc, pc_src); end
    total++; if (f_ras_pred !== '0 || ras_mispredict !== 1'b0) begin bad++; $display("FAIL ret_noras got=%h/%b want=0/0", f_ras_pred, ras_mispredict); end
    idle(); f_icode = 4'h9; f_valC = 64'h55; f_valP = 64'h66;
    tick();
    total++; if (pred_pc !== 64'h66) begin bad++; $display("FAIL ret_valp got=%h want=%h", pred_pc, 64'h66); end
`endif
    idle();
    tick();
  endtask

  task automatic test_overflow();
    logic [AW-1:0] want;
    idle();
    reset = 1; #2; reset = 0;
    exp_pred = RPC; ras_q.delete();
    for (int i = 1; i <= 5; i++) begin
      f_icode = 4'h8; f_valP = AW'(i); f_valC = 64'h1000;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      f_icode = 4'h9; f_valP = 64'h900 + AW'(i);
`ifdef PCSEL_RAS_EN
      want = (i < 4) ? AW'(5 - i) : 64'h904;
`else
      want = '0;
`endif
      #1;
      total++; if (f_ras_pred !== want) begin bad++; $display("FAIL ovf_pop%0d got=%h want=%h", i, f_ras_pred, want); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      f_stall    = ($urandom_range(0, 3) == 0);
      f_icode    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(7, 9)) : 4'($urandom);
      f_valC     = r64();
      f_valP     = r64();
      m_icode    = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom);
      m_cnd      = 1'($urandom);
      m_valA     = r64();
      w_icode    = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom);
      w_valM     = r64();
      w_ras_pred = ($urandom_range(0, 1) == 0) ? w_valM : r64();
      #1;
      model_eval();
      total++;
      if (f_pc !== e_fpc || pc_src !== e_src || redirect !== e_red ||
          f_ras_pred !== e_rasp || ras_mispredict !== e_misp) begin
        bad++;
        $display("FAIL rand_comb%0d got=%h/%0d/%b/%h/%b want=%h/%0d/%b/%h/%b", n,
                 f_pc, pc_src, redirect, f_ras_pred, ras_mispredict,
                 e_fpc, e_src, e_red, e_rasp, e_misp);
      end
      tick();
      total++; if (pred_pc !== exp_pred) begin bad++; $display("FAIL rand_pred%0d got=%h want=%h", n, pred_pc, exp_pred); end
    end
  endtask

  task automatic test_async_reset();
    idle();
    f_icode = 4'h8; f_valP = 64'h44; f_valC = 64'hABC;
    tick();
    idle();
    #2;
    reset = 1;
    #1;
    exp_pred = RPC; ras_q.delete();
    total++; if (pred_pc !== 64'h100 || f_pc !== 64'h100) begin bad++; $display("FAIL async_reset got=%h/%h want=100/100", pred_pc, f_pc); end
    #1;
    reset = 0;
    f_icode = 4'h9; f_valP = 64'h3333;
    #1;
    model_eval();
    total++; if (f_ras_pred !== e_rasp) begin bad++; $display("FAIL reset_ras got=%h want=%h", f_ras_pred, e_rasp); end
    f_icode = 4'h6;
    tick();
    total++; if (pred_pc !== 64'h3333) begin bad++; $display("FAIL post_reset got=%h want=%h", pred_pc, 64'h3333); end
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_branch();
    test_priority();
    test_stall();
    test_return();
    test_overflow();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_select_unit.md
Name: pc_select_unit

Overview:
- Fetch-stage PC generation for the 5-stage pipelined Y86-64 core; registered successor of the single-cycle PC update logic.
- Holds the predicted-PC register (F_predPC) and produces the fetch address each cycle.
- The fetch address comes from the prediction, the M-stage branch-misprediction recovery or the W-stage return target.
- Parametrised in address width and reset vector, with an optional return-address stack (RAS).

Parameters:
- ADDR_W, 64, width of all PC/address buses
- RESET_PC, 0, value loaded into pred_pc on reset
- RAS_DEPTH, 8, RAS entries (power of 2, >=2); used only with PCSEL_RAS_EN

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- f_stall  in  1  hold pred_pc and RAS this cycle (from hazard control)
- f_icode  in  4  icode of instruction fetched at f_pc this cycle
- f_valC  in  ADDR_W  fetched constant (jump/call target)
- f_valP  in  ADDR_W  fall-through address of fetched instruction
- m_icode  in  4  M-stage icode
- m_cnd  in  1  M-stage condition result
- m_valA  in  ADDR_W  M-stage valA (fall-through carried by JXX)
- w_icode  in  4  W-stage icode
- w_valM  in  ADDR_W  W-stage loaded value (actual return address)
- w_ras_pred  in  ADDR_W  RAS prediction carried down the pipe with RET; ignored without PCSEL_RAS_EN
- f_pc  out  ADDR_W  fetch address (combinational)
- pred_pc  out  ADDR_W  predicted-PC register
- pc_src  out  2  0=pred, 1=branch recovery, 2=return, 3=reserved (never driven)
- redirect  out  1  pc_src != 0
- f_ras_pred  out  ADDR_W  RAS target for a RET fetched this cycle; 0 without the macro
- ras_mispredict  out  1  W-stage RET target differs from its prediction; 0 without the macro

Behaviour:
- Encodings: HALT 0, NOP 1, RRMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OP 6, JXX 7, CALL 8, RET 9, PUSH A, POP B.
- f_pc priority, combinational:
  - (1) m_icode==7 && !m_cnd -> m_valA, pc_src=1.
  - (2) W-stage return redirect, defined below -> w_valM, pc_src=2.
  - (3) otherwise pred_pc, pc_src=0.
- Both (1) and (2) true in the same cycle -> (1) wins.
- Next-prediction value:
  - JXX or CALL -> f_valC (branches predicted taken).
  - RET -> f_ras_pred with the macro; f_valP without it (hazard unit stalls).
  - All other icodes, including invalid 0xC-0xF -> f_valP.
- HALT -> f_valP. Halting is the status logic's job.
- pred_pc update: on rising clk when !f_stall, load next-prediction. A redirect does not block the load; the decode uses the redirected f_pc.
- f_stall=1: pred_pc and RAS hold exactly; f_pc still follows the priority rules.
- reset asserted, asynchronous: pred_pc=RESET_PC, RAS cleared (count 0, pointer 0).
  - Outputs then settle combinationally: f_pc=RESET_PC if no redirect condition is on the inputs, pc_src=0, ras_mispredict=0.
- Reset deasserting mid-operation: the first edge after deassertion performs a normal update.
- Widths: all address arithmetic is ADDR_W wide. No adders inside; f_valP comes from fetch.

Optional Feature:
- Macro PCSEL_RAS_EN.
- Defined: RAS_DEPTH x ADDR_W circular stack, top pointer plus saturating count 0..RAS_DEPTH.
  - Push f_valP on fetched CALL, pop on fetched RET; both only when !f_stall && !redirect.
  - f_ras_pred = top entry when count>0, else f_valP.
  - Push when full: overwrite oldest entry, pointer wraps, count stays RAS_DEPTH.
  - Pop when count==0: no state change.
  - Return redirect (2) fires when w_icode==9 && w_valM != w_ras_pred; ras_mispredict is asserted in exactly that case.
  - No RAS repair on misprediction.
- Undefined: no stack storage.
  - Return redirect (2) fires whenever w_icode==9.
  - f_ras_pred=0, ras_mispredict=0.

Test Plan:
- Reset with RESET_PC=0x100 -> pred_pc=0x100, f_pc=0x100, pc_src=0. Release, fetch OP with f_valP=0x102 -> pred_pc=0x102 after 1 edge.
- Fetch JXX, f_valC=0x40 -> pred_pc=0x40. Two cycles later m_icode=7, m_cnd=0, m_valA=0x209 -> f_pc=0x209, pc_src=1. With m_cnd=1 -> f_pc=pred_pc.
- Same cycle: m_icode=7, m_cnd=0, m_valA=0x30, and w_icode=9, w_valM=0x50 -> f_pc=0x30, pc_src=1.
- f_stall=1 for 3 cycles with CALL fetched -> pred_pc unchanged and no RAS push. Drop stall -> pred_pc=f_valC.
- Macro on: CALL at f_valP=0x10, then RET fetched -> f_ras_pred=0x10, pred_pc=0x10. Later w_icode=9, w_valM=0x10, w_ras_pred=0x10 -> no redirect. With w_valM=0x88 -> f_pc=0x88, ras_mispredict=1.
- Macro on, RAS_DEPTH=4: 5 CALLs (valP 1..5) then 5 RETs -> predictions 5,4,3,2, then f_valP (underflow). Macro off: W-stage RET w_valM=0x77 -> f_pc=0x77, pc_src=2.
